intr_controller: RTL and testbench

//  Memory-mapped interrupt controller on the shared I/O bus (ABUS/DBUS/we), alongside the KEY/SW/LED/HEX/timer devices.
//  - Latches rising edges of device interrupt requests as pending bits.
//  - Applies per-source and global enables, then selects one source by fixed priority.
//  - Runs the irq/ack/iret handshake with the CPU controller, which redirects the PC to the handler.
//  - One interrupt in service at a time; no nesting.

---
 rtl/intr_controller_pkg.sv | 16 +
 rtl/intr_controller_if.sv | 26 ++
 rtl/intr_prio_enc.sv | 20 ++
 rtl/intr_controller.sv | 144 ++++++++++++++
 tb/tb_intr_controller.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intr_controller_pkg.sv
// Interrupt controller shared definitions:
// register addresses and FSM encoding.
package intr_controller_pkg;

  localparam logic [31:0] ADDR_IE = 32'hF000_0020;
  localparam logic [31:0] ADDR_IP = 32'hF000_0024;
  localparam logic [31:0] ADDR_ID = 32'hF000_0028;
  localparam int GIE_BIT = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/intr_controller_if.sv
// irq/ack/iret handshake between the interrupt
// controller and the CPU controller.
interface intr_controller_if #(
  parameter int ID_BITS = 2
) ();

  logic               irq;
  logic [ID_BITS-1:0] irq_id;
  logic               irq_ack;
  logic               iret;

  modport master (
    output irq,
    output irq_id,
    input  irq_ack,
    input  iret
  );

  modport slave (
    input  irq,
    input  irq_id,
    output irq_ack,
    output iret
  );

endinterface

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Combinational, any_o flags a non-empty vector.
module intr_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    any_o = |vec_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/intr_controller.sv
// Memory-mapped interrupt controller: edge capture,
// enables, fixed-priority select and irq handshake.
module intr_controller
  import intr_controller_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ABUS,
  inout  wire  [31:0]        DBUS,
  input  logic               we,
  input  logic [NUM_SRC-1:0] src_req,
  intr_controller_if.master  cpu
);

  state_e               state_q, state_d;
  logic                 gie_q, gie_d;
  logic [NUM_SRC-1:0]   ie_q, ie_d;
  logic [NUM_SRC-1:0]   ip_q, ip_d;
  logic [NUM_SRC-1:0]   prev_q;
  logic                 irq_q, irq_d;
  logic [ID_BITS-1:0]   irq_id_q, irq_id_d;
  logic [ID_BITS-1:0]   svc_q, svc_d;

  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   cand;
  logic [NUM_SRC-1:0]   ack_clr;
  logic                 any;
  logic [ID_BITS-1:0]   sel;
  logic                 hit_ie, hit_ip, hit_id;
  logic [31:0]          rdata;
  logic                 unused_dbus;

  assign hit_ie = (ABUS == ADDR_IE);
  assign hit_ip = (ABUS == ADDR_IP);
  assign hit_id = (ABUS == ADDR_ID);
  assign rise   = src_req & ~prev_q;
  assign cand   = ip_q & ie_q & {NUM_SRC{gie_q}};
  assign unused_dbus = ^DBUS[30:NUM_SRC];

  intr_prio_enc #(
    .N (NUM_SRC),
    .W (ID_BITS)
  ) u_prio (
    .vec_i (cand),
    .any_o (any),
    .idx_o (sel)
  );

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    irq_id_d = irq_id_q;
    svc_d    = svc_q;
    ack_clr  = '0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          irq_d    = 1'b1;
          irq_id_d = sel;
          state_d  = ASSERT;
        end
      end
      ASSERT: begin
        // ack beats withdrawal when both land together
        if (cpu.irq_ack) begin
          irq_d   = 1'b0;
          svc_d   = irq_id_q;
          ack_clr = NUM_SRC'(1) << irq_id_q;
          state_d = SERVICE;
        end else if (!cand[irq_id_q]) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (cpu.iret) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    gie_d = gie_q;
    ie_d  = ie_q;
    if (we && hit_ie) begin
      gie_d = DBUS[GIE_BIT];
      ie_d  = DBUS[NUM_SRC-1:0];
    end
    ip_d = ip_q;
    if (we && hit_ip) ip_d = ip_d & ~DBUS[NUM_SRC-1:0];
    // fresh edges are applied last so they win over clears
    ip_d = (ip_d & ~ack_clr) | rise;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_ie: begin
        rdata[GIE_BIT]       = gie_q;
        rdata[NUM_SRC-1:0]   = ie_q;
      end
      hit_ip: rdata[NUM_SRC-1:0] = ip_q;
      hit_id: begin
        rdata[31]            = (state_q == SERVICE);
        rdata[ID_BITS-1:0]   = svc_q;
      end
      default: rdata = '0;
    endcase
  end

  assign DBUS = (!we && (hit_ie || hit_ip || hit_id)) ? rdata : 'z;

  assign cpu.irq    = irq_q;
  assign cpu.irq_id = irq_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gie_q    <= 1'b0;
      ie_q     <= '0;
      ip_q     <= '0;
      prev_q   <= '0;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
      svc_q    <= '0;
    end else begin
      state_q  <= state_d;
      gie_q    <= gie_d;
      ie_q     <= ie_d;
      ip_q     <= ip_d;
      prev_q   <= src_req;
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
      svc_q    <= svc_d;
    end
  end

endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller: handshake,
// priority, enables, W1C races and reset abandon.
module tb_intr_controller;
  import intr_controller_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] ABUS;
  logic        we;
  logic [3:0]  src_req;
  logic        tb_drv;
  logic [31:0] tb_wdata;
  wire  [31:0] DBUS;
  int          total;
  int          bad;
  logic [31:0] rd;

  intr_controller_if #(.ID_BITS(2)) cpu_if ();

  intr_controller #(
    .NUM_SRC (4),
    .ID_BITS (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ABUS    (ABUS),
    .DBUS    (DBUS),
    .we      (we),
    .src_req (src_req),
    .cpu     (cpu_if)
  );

  assign DBUS = tb_drv ? tb_wdata : 'z;

  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup (DBUS[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    ABUS     = a;
    we       = 1'b1;
    tb_drv   = 1'b1;
    tb_wdata = d;
    tick();
    we       = 1'b0;
    tb_drv   = 1'b0;
    ABUS     = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    ABUS = a;
    we   = 1'b0;
    #1;
    d    = DBUS;
    ABUS = 32'h0;
    #1;
  endtask

  task automatic pulse_ack();
    cpu_if.irq_ack = 1'b1;
    tick();
    cpu_if.irq_ack = 1'b0;
  endtask

  task automatic pulse_iret();
    cpu_if.iret = 1'b1;
    tick();
    cpu_if.iret = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (cpu_if.irq !== 1'b0) begin
      bad++;
      $display("FAIL rst_irq got=%b exp=0", cpu_if.irq);
    end
    total++;
    if (cpu_if.irq_id !== 2'd0) begin
      bad++;
      $display("FAIL rst_irq_id got=%0d exp=0", cpu_if.irq_id);
    end
    bus_read(ADDR_IE, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL rst_ie got=%h exp=00000000", rd);
    end
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL rst_ip got=%h exp=00000000", rd);
    end
    bus_read(ADDR_ID, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL rst_id got=%h exp=00000000", rd);
    end
  endtask

  task automatic test_single();
    bus_write(ADDR_IE, 32'h8000_0002);
    bus_read(ADDR_IE, rd);
    total++;
    if (rd !== 32'h8000_0002) begin
      bad++;
      $display("FAIL single_ie got=%h exp=80000002", rd);
    end
    src_req = 4'b0010;
    tick();
    src_req = 4'b0000;
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'h2) begin
      bad++;
      $display("FAIL single_ip got=%h exp=00000002", rd);
    end
    total++;
    if (cpu_if.irq !== 1'b0) begin
      bad++;
      $display("FAIL single_irq_early got=%b exp=0", cpu_if.irq);
    end
    tick();
    total++;
    if (cpu_if.irq !== 1'b1 || cpu_if.irq_id !== 2'd1) begin
      bad++;
      $display("FAIL single_irq got=%b/%0d exp=1/1", cpu_if.irq, cpu_if.irq_id);
    end
    pulse_ack();
    total++;
    if (cpu_if.irq !== 1'b0) begin
      bad++;
      $display("FAIL single_ack_irq got=%b exp=0", cpu_if.irq);
    end
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL single_ack_ip got=%h exp=00000000", rd);
    end
    bus_read(ADDR_ID, rd);
    total++;
    if (rd !== 32'h8000_0001) begin
      bad++;
      $display("FAIL single_id got=%h exp=80000001", rd);
    end
    pulse_iret();
    bus_read(ADDR_ID, rd);
    total++;
    if (rd !== 32'h0000_0001) begin
      bad++;
      $display("FAIL single_iret_id got=%h exp=00000001", rd);
    end
  endtask

  task automatic test_priority();
    bus_write(ADDR_IE, 32'h8000_000F);
    src_req = 4'b1010;
    tick();
    src_req = 4'b0000;
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'hA) begin
      bad++;
      $display("FAIL prio_ip got=%h exp=0000000a", rd);
    end
    tick();
    total++;
    if (cpu_if.irq !== 1'b1 || cpu_if.irq_id !== 2'd1) begin
      bad++;
      $display("FAIL prio_first got=%b/%0d exp=1/1", cpu_if.irq, cpu_if.irq_id);
    end
    pulse_ack();
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'h8) begin
      bad++;
      $display("FAIL prio_ip_after_ack got=%h exp=00000008", rd);
    end
    tick();
    total++;
    if (cpu_if.irq !== 1'b0) begin
      bad++;
      $display("FAIL prio_no_nest got=%b exp=0", cpu_if.irq);
    end
    pulse_iret();
    total++;
    if (cpu_if.irq !== 1'b0) begin
      bad++;
      $display("FAIL prio_iret_edge got=%b exp=0", cpu_if.irq);
    end
    tick();
    total++;
    if (cpu_if.irq !== 1'b1 || cpu_if.irq_id !== 2'd3) begin
      bad++;
      $display("FAIL prio_second got=%b/%0d exp=1/3", cpu_if.irq, cpu_if.irq_id);
    end
    pulse_ack();
    pulse_iret();
  endtask

  task automatic test_gie();
    bus_write(ADDR_IE, 32'h0000_0004);
    src_req = 4'b0100;
    tick();
    src_req = 4'b0000;
    tick();
    tick();
    total++;
    if (cpu_if.irq !== 1'b0) begin
      bad++;
      $display("FAIL gie_off_irq got=%b exp=0", cpu_if.irq);
    end
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'h4) begin
      bad++;
      $display("FAIL gie_off_ip got=%h exp=00000004", rd);
    end
    bus_write(ADDR_IE, 32'h8000_0004);
    total++;
    if (cpu_if.irq !== 1'b0) begin
      bad++;
      $display("FAIL gie_on_early got=%b exp=0", cpu_if.irq);
    end
    tick();
    total++;
    if (cpu_if.irq !== 1'b1 || cpu_if.irq_id !== 2'd2) begin
      bad++;
      $display("FAIL gie_on_irq got=%b/%0d exp=1/2", cpu_if.irq, cpu_if.irq_id);
    end
    pulse_ack();
    pulse_iret();
  endtask

  task automatic test_withdraw();
    bus_write(ADDR_IE, 32'h8000_0001);
    src_req = 4'b0001;
    tick();
    src_req = 4'b0000;
    tick();
    total++;
    if (cpu_if.irq !== 1'b1 || cpu_if.irq_id !== 2'd0) begin
      bad++;
      $display("FAIL wd_irq got=%b/%0d exp=1/0", cpu_if.irq, cpu_if.irq_id);
    end
    bus_write(ADDR_IP, 32'h1);
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL wd_ip got=%h exp=00000000", rd);
    end
    total++;
    if (cpu_if.irq !== 1'b1) begin
      bad++;
      $display("FAIL wd_irq_hold got=%b exp=1", cpu_if.irq);
    end
    tick();
    total++;
    if (cpu_if.irq !== 1'b0) begin
      bad++;
      $display("FAIL wd_drop got=%b exp=0", cpu_if.irq);
    end
    pulse_ack();
    total++;
    if (cpu_if.irq !== 1'b0) begin
      bad++;
      $display("FAIL wd_stray_ack got=%b exp=0", cpu_if.irq);
    end
    bus_read(ADDR_ID, rd);
    total++;
    if (rd[31] !== 1'b0) begin
      bad++;
      $display("FAIL wd_not_svc got=%h exp=bit31 clear", rd);
    end
  endtask

  task automatic test_w1c_race();
    bus_write(ADDR_IE, 32'h0);
    src_req = 4'b0100;
    tick();
    src_req = 4'b0000;
    tick();
    src_req = 4'b0100;
    bus_write(ADDR_IP, 32'h4);
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'h4) begin
      bad++;
      $display("FAIL race_ip got=%h exp=00000004", rd);
    end
    bus_write(ADDR_IP, 32'h4);
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL w1c_level_ip got=%h exp=00000000", rd);
    end
    tick();
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL level_once got=%h exp=00000000", rd);
    end
    src_req = 4'b0000;
    bus_read(32'hF000_0030, rd);
    total++;
    if (rd !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL float_bus got=%h exp=ffffffff", rd);
    end
    bus_write(ADDR_ID, 32'h8000_0003);
    bus_read(ADDR_ID, rd);
    total++;
    if (rd[31] !== 1'b0) begin
      bad++;
      $display("FAIL id_ro got=%h exp=bit31 clear", rd);
    end
  endtask

  task automatic test_reset_in_service();
    bus_write(ADDR_IE, 32'h8000_0008);
    src_req = 4'b1000;
    tick();
    src_req = 4'b0000;
    tick();
    pulse_ack();
    src_req = 4'b1000;
    tick();
    src_req = 4'b0000;
    bus_read(ADDR_ID, rd);
    total++;
    if (rd !== 32'h8000_0003) begin
      bad++;
      $display("FAIL svc_id got=%h exp=80000003", rd);
    end
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'h8) begin
      bad++;
      $display("FAIL svc_ip got=%h exp=00000008", rd);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (cpu_if.irq !== 1'b0) begin
      bad++;
      $display("FAIL rst2_irq got=%b exp=0", cpu_if.irq);
    end
    bus_read(ADDR_IP, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL rst2_ip got=%h exp=00000000", rd);
    end
    bus_read(ADDR_IE, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL rst2_ie got=%h exp=00000000", rd);
    end
    bus_read(ADDR_ID, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL rst2_id got=%h exp=00000000", rd);
    end
    pulse_iret();
    pulse_ack();
    tick();
    total++;
    if (cpu_if.irq !== 1'b0) begin
      bad++;
      $display("FAIL stray_irq got=%b exp=0", cpu_if.irq);
    end
    bus_read(ADDR_ID, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL stray_id got=%h exp=00000000", rd);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    ABUS           = 32'h0;
    we             = 1'b0;
    src_req        = 4'b0;
    tb_drv         = 1'b0;
    tb_wdata       = 32'h0;
    cpu_if.irq_ack = 1'b0;
    cpu_if.iret    = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_gie();
    test_withdraw();
    test_w1c_race();
    test_reset_in_service();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
